// File: rtl/div_unit.sv
// Iterative 32-bit divider (div/divu/rem/remu): one radix-2 restoring step per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        done,
    output logic [31:0] y
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_rem;
    logic        r_b_zero;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_div;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic        r_ready;
    logic        r_done;
    logic [31:0] r_y;

    // Operand preparation at acceptance: op[0]=0 selects the signed variants.
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_b_zero;
    logic        w_early;
    logic [31:0] w_early_y;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[31];
    assign w_b_neg  = w_signed & b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;
    assign w_b_zero = (b == 32'd0);

`ifdef DIV_EARLY_OUT_EN
    logic w_ovf;
    assign w_ovf     = w_signed & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    assign w_early   = w_b_zero | w_ovf;
    assign w_early_y = w_b_zero ? (op[1] ? a : 32'hFFFF_FFFF)
                                : (op[1] ? 32'd0 : 32'h8000_0000);
`else
    assign w_early   = 1'b0;
    assign w_early_y = 32'd0;
`endif

    // Restoring step: shift the next dividend bit into the partial remainder,
    // then keep the 33-bit trial difference only if it did not borrow.
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_fit;
    logic [31:0] w_quo_next;
    logic [31:0] w_rem_next;

    assign w_shift    = {r_rem, r_quo[31]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_fit      = ~w_trial[32];
    assign w_quo_next = {r_quo[30:0], w_fit};
    assign w_rem_next = w_fit ? w_trial[31:0] : w_shift[31:0];

    // Sign fixup on the final step; a zero divisor forces the all-ones quotient,
    // while its remainder (|a| re-signed like a) already equals a.
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_res;

    assign w_q_fix = r_b_zero ? 32'hFFFF_FFFF
                              : (r_neg_q ? (32'd0 - w_quo_next) : w_quo_next);
    assign w_r_fix = r_neg_r ? (32'd0 - w_rem_next) : w_rem_next;
    assign w_res   = r_is_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_is_rem <= 1'b0;
            r_b_zero <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div    <= 32'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_y      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_is_rem <= op[1];
                        r_b_zero <= w_b_zero;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div    <= w_b_mag;
                        r_quo    <= w_a_mag;
                        r_rem    <= 32'd0;
                        r_cnt    <= 5'd0;
                        r_ready  <= 1'b0;
                        if (w_early) begin
                            r_state <= S_DONE;
                            r_y     <= w_early_y;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_DONE;
                        r_y     <= w_res;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign y     = r_y;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, random operations against
// an arithmetic reference model, start-ignore, reset abort and back-to-back throughput.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] y;

    int n_checks = 0;
    int n_pass   = 0;

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result computed with native integer arithmetic plus the special cases.
    function automatic logic [31:0] model_y(input logic [1:0] o, input logic [31:0] aa,
                                            input logic [31:0] bb);
        int  sa;
        int  sb;
        logic ovf;
        sa  = aa;
        sb  = bb;
        ovf = (aa == 32'h8000_0000) && (bb == 32'hFFFF_FFFF);
        case (o)
            2'd0:    model_y = (bb == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2'd1:    model_y = (bb == 0) ? 32'hFFFF_FFFF : aa / bb;
            2'd2:    model_y = (bb == 0) ? aa : (ovf ? 32'd0 : 32'(sa % sb));
            default: model_y = (bb == 0) ? aa : aa % bb;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] aa,
                                     input logic [31:0] bb);
`ifdef DIV_EARLY_OUT_EN
        if (bb == 0 || (!o[0] && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF))
            model_lat = 1;
        else
            model_lat = 33;
`else
        model_lat = 33 + 0 * int'(o) + 0 * int'(aa[0]) + 0 * int'(bb[0]);
`endif
    endfunction

    // Waits (bounded) for the unit to be idle; returns at a falling edge.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Issues one request and returns the result and the cycle (after acceptance) of done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          output logic [31:0] yy, output int lat);
        bit ok;
        wait_ready(ok);
        yy  = 32'hDEAD_BEEF;
        lat = 0;
        if (ok) begin
            op = o; a = aa; b = bb; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            a = $urandom; b = $urandom; op = 2'($urandom);
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (done) begin
                    lat = k;
                    yy  = y;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || y !== 32'd0)
            $display("FAIL reset_state: ready=%b done=%b y=%h, required ready=1 done=0 y=0",
                     ready, done, y);
        else n_pass++;
        reset = 1'b0; start = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [12] = '{0, 2, 0, 2, 1, 1, 3, 0, 2, 0, 2, 3};
        logic [31:0] t_a  [12] = '{100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 5, 5,
                                   32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB,
                                   32'hFFFF_FFFF};
        logic [31:0] t_b  [12] = '{7, 7, 2, 2, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
                                   32'h8000_0000};
        logic [31:0] t_y  [12] = '{14, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 5, 32'h8000_0000, 0, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFB, 32'h7FFF_FFFF};
        logic [31:0] got;
        logic [31:0] held;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], got, lat);
            n_checks++;
            if (got !== t_y[i] || lat != model_lat(t_op[i], t_a[i], t_b[i]))
                $display("FAIL directed_%0d: op=%0d a=%h b=%h y=%h lat=%0d, required y=%h lat=%0d",
                         i, t_op[i], t_a[i], t_b[i], got, lat, t_y[i],
                         model_lat(t_op[i], t_a[i], t_b[i]));
            else n_pass++;
            held = got;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || ready !== 1'b1 || y !== held)
                $display("FAIL done_pulse_%0d: done=%b ready=%b y=%h, required done=0 ready=1 y=%h",
                         i, done, ready, y, held);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [31:0] got;
        int          lat;
        int          sel;
        for (int i = 0; i < 24; i++) begin
            o   = 2'($urandom);
            aa  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      bb = 32'd0;
            else if (sel == 1) bb = $urandom_range(1, 15);
            else if (sel == 2) begin aa = 32'h8000_0000; bb = 32'hFFFF_FFFF; end
            else if (sel == 3) bb = 32'hFFFF_FFFF - $urandom_range(0, 20);
            else               bb = $urandom;
            run_op(o, aa, bb, got, lat);
            n_checks++;
            if (got !== model_y(o, aa, bb) || lat != model_lat(o, aa, bb))
                $display("FAIL random_%0d: op=%0d a=%h b=%h y=%h lat=%0d, required y=%h lat=%0d",
                         i, o, aa, bb, got, lat, model_y(o, aa, bb), model_lat(o, aa, bb));
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        bit          ok;
        int          lat;
        logic [31:0] got;
        logic        rdy_mid;
        wait_ready(ok);
        op = 2'd0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0; got = 32'hDEAD_BEEF; rdy_mid = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) begin
                rdy_mid = ready;
                start = 1'b1; op = 2'd3; a = 32'd12345; b = 32'd3;
            end
            if (k == 7) start = 1'b0;
            if (done) begin
                lat = k;
                got = y;
                break;
            end
        end
        start = 1'b0;
        n_checks++;
        if (got !== 32'd14 || lat != 33 || rdy_mid !== 1'b0)
            $display("FAIL start_ignored: y=%h lat=%0d ready_mid=%b, required y=0000000e lat=33 ready_mid=0",
                     got, lat, rdy_mid);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        bit   ok;
        int   seen;
        wait_ready(ok);
        op = 2'd1; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || y !== 32'd0 || done !== 1'b0)
            $display("FAIL reset_abort: ready=%b y=%h done=%b, required ready=1 y=0 done=0",
                     ready, y, done);
        else n_pass++;
        seen = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_checks++;
        if (seen != 0)
            $display("FAIL abort_no_done: done pulses=%0d, required 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit          ok;
        logic [1:0]  o;
        logic [31:0] aa;
        logic [31:0] bb;
        int          gap;
        int          want;
        wait_ready(ok);
        o = 2'($urandom); aa = $urandom; bb = $urandom_range(1, 5000);
        op = o; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            gap = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (done) begin
                    gap = k;
                    break;
                end
            end
            want = (n == 0) ? 33 : 34;
            n_checks++;
            if (y !== model_y(o, aa, bb) || gap != want)
                $display("FAIL back_to_back_%0d: op=%0d a=%h b=%h y=%h gap=%0d, required y=%h gap=%0d",
                         n, o, aa, bb, y, gap, model_y(o, aa, bb), want);
            else n_pass++;
            o = 2'($urandom); aa = $urandom; bb = $urandom_range(1, 5000);
            op = o; a = aa; b = bb;
            if (n == 3) start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
